// File: rtl/store_buffer.sv
// store_buffer: MEM-stage store path. Formats SB/SH/SW data and byte enables into data-memory
// lane order (byte offset 0 -> bits [31:24]) and queues them in an in-order FIFO of DEPTH entries.
// The FIFO drains one entry per cycle to the data-memory write port. Loads that hit a pending
// store word are flagged so the pipeline can stall.
//
// Optional feature macro: STB_MERGE_EN. When defined, a store to the same word as the youngest
// entry merges into that entry instead of allocating a new one.
//
// Ports:
//   cpu_clk_50M, cpu_rst        clock, synchronous active-high reset
//   st_valid/st_ready           store request handshake from MEM stage
//   st_size/st_addr/st_data     store size (00 B, 01 H, 1x W), byte address, register value
//   st_ades                     misaligned store (combinational, no enqueue)
//   ld_check/ld_addr/ld_hazard  load word-address match against pending stores
//   dm_we/dm_addr/dm_din/dm_ack head entry presented to data memory; ack pops it
//   sb_empty/count              occupancy status
module store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             cpu_clk_50M,
   input  logic             cpu_rst,
   input  logic             st_valid,
   output logic             st_ready,
   input  logic [1:0]       st_size,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   output logic             st_ades,
   input  logic             ld_check,
   input  logic [31:0]      ld_addr,
   output logic             ld_hazard,
   output logic [3:0]       dm_we,
   output logic [31:0]      dm_addr,
   output logic [31:0]      dm_din,
   input  logic             dm_ack,
   output logic             sb_empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [29:0]      addr_q [DEPTH];
   logic [29:0]      addr_d [DEPTH];
   logic [3:0]       we_q   [DEPTH];
   logic [3:0]       we_d   [DEPTH];
   logic [31:0]      din_q  [DEPTH];
   logic [31:0]      din_d  [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, last_idx;
   logic [CNT_W-1:0] count_q, count_d;

   logic [3:0]  fmt_we;
   logic [31:0] fmt_din;
   logic        push, pop, alloc, merge_hit, has_room;
   logic        unused_ld;

   assign unused_ld = ^ld_addr[1:0];

   // Lane formatting: byte offset 0 lands in bits [31:24].
   always_comb begin
      fmt_we  = 4'b0000;
      fmt_din = 32'h0;
      case (st_size)
         2'b00: begin
            fmt_we  = 4'b1000 >> st_addr[1:0];
            fmt_din = {st_data[7:0], 24'h0} >> {st_addr[1:0], 3'b000};
         end
         2'b01: begin
            if (!st_addr[1]) begin
               fmt_we  = 4'b1100;
               fmt_din = {st_data[7:0], st_data[15:8], 16'h0};
            end else begin
               fmt_we  = 4'b0011;
               fmt_din = {16'h0, st_data[7:0], st_data[15:8]};
            end
         end
         default: begin
            fmt_we  = 4'b1111;
            fmt_din = {st_data[7:0], st_data[15:8], st_data[23:16], st_data[31:24]};
         end
      endcase
   end

   assign st_ades  = st_valid && (((st_size == 2'b01) && st_addr[0]) ||
                                  (st_size[1] && (st_addr[1:0] != 2'b00)));
   assign sb_empty = (count_q == '0);
   assign count    = count_q;
   assign last_idx = tail_q - PTR_W'(1);
   assign has_room = (count_q < CNT_W'(DEPTH));
   assign pop      = !sb_empty && dm_ack;

`ifdef STB_MERGE_EN
   // Youngest entry may absorb a same-word store unless it is the head leaving this cycle.
   assign merge_hit = !sb_empty && (addr_q[last_idx] == st_addr[31:2]) &&
                      !(pop && (count_q == CNT_W'(1)));
   assign st_ready  = has_room || merge_hit;
`else
   assign merge_hit = 1'b0;
   assign st_ready  = has_room;
`endif

   assign push  = st_valid && !st_ades && st_ready;
   assign alloc = push && !merge_hit;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      we_d    = we_q;
      din_d   = din_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end
`ifdef STB_MERGE_EN
      if (push && merge_hit) begin
         we_d[last_idx] = we_q[last_idx] | fmt_we;
         for (int i = 0; i < 4; i++) begin
            if (fmt_we[i]) din_d[last_idx][8*i +: 8] = fmt_din[8*i +: 8];
         end
      end
`endif
      if (alloc) begin
         valid_d[tail_q] = 1'b1;
         addr_d[tail_q]  = st_addr[31:2];
         we_d[tail_q]    = fmt_we;
         din_d[tail_q]   = fmt_din;
         tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            we_q[i]   <= '0;
            din_q[i]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         din_q   <= din_d;
      end
   end

   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i] == ld_addr[31:2])) ld_hazard = ld_check;
      end
   end

   assign dm_we   = sb_empty ? 4'b0000 : we_q[head_q];
   assign dm_addr = sb_empty ? 32'h0 : {addr_q[head_q], 2'b00};
   assign dm_din  = sb_empty ? 32'h0 : din_q[head_q];

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        cpu_rst;
   logic        st_valid, st_ready, st_ades;
   logic [1:0]  st_size;
   logic [31:0] st_addr, st_data;
   logic        ld_check, ld_hazard;
   logic [31:0] ld_addr;
   logic [3:0]  dm_we;
   logic [31:0] dm_addr, dm_din;
   logic        dm_ack, sb_empty;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] din;
   } exp_t;
   exp_t exp_q[$];

   store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
      .cpu_clk_50M(clk), .cpu_rst(cpu_rst),
      .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size), .st_addr(st_addr),
      .st_data(st_data), .st_ades(st_ades),
      .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_ack(dm_ack),
      .sb_empty(sb_empty), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every accepted memory write must match the oldest expected write.
   always @(negedge clk) begin
      if (!cpu_rst && dm_ack && !sb_empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h we %b din %h expected none",
                     dm_addr, dm_we, dm_din);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_addr", dm_addr, e.addr);
            chk("wr_we", {28'h0, dm_we}, {28'h0, e.we});
            chk("wr_din", dm_din, e.din);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the push edge.
   task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] ew, input logic [31:0] ed, input bit expect_wr);
      exp_t e;
      st_valid = 1'b1;
      st_size  = sz;
      st_addr  = a;
      st_data  = d;
      @(negedge clk);
      chk("st_ades_aligned", {31'h0, st_ades}, 32'h0);
      if (expect_wr) begin
         e.addr = {a[31:2], 2'b00};
         e.we   = ew;
         e.din  = ed;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 st_valid = 1'b0;
   endtask

   task automatic ack(input int n);
      dm_ack = 1'b1;
      repeat (n) @(posedge clk);
      #1 dm_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cpu_rst = 1'b1; st_valid = 1'b0; st_size = 2'b00; st_addr = 32'h0; st_data = 32'h0;
      ld_check = 1'b0; ld_addr = 32'h0; dm_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dm_we", {28'h0, dm_we}, 32'h0);
      chk("rst_dm_addr", dm_addr, 32'h0);
      chk("rst_dm_din", dm_din, 32'h0);
      chk("rst_st_ready", {31'h0, st_ready}, 32'h1);
      chk("rst_sb_empty", {31'h0, sb_empty}, 32'h1);
      chk("rst_count", {29'h0, count}, 32'h0);
      chk("rst_ld_hazard", {31'h0, ld_hazard}, 32'h0);
      chk("rst_st_ades", {31'h0, st_ades}, 32'h0);
      @(posedge clk);
      #1 cpu_rst = 1'b0;

      // Word store, then drain.
      store(2'b10, 32'h100, 32'h11223344, 4'b1111, 32'h44332211, 1'b1);
      @(negedge clk);
      chk("sw_count", {29'h0, count}, 32'h1);
      chk("sw_dm_addr", dm_addr, 32'h100);
      @(posedge clk); #1;
      ack(1);
      @(negedge clk);
      chk("sw_drained_empty", {31'h0, sb_empty}, 32'h1);

      // Byte and halfword lane formatting.
      @(posedge clk); #1;
      store(2'b00, 32'h203, 32'h000000AB, 4'b0001, 32'h000000AB, 1'b1);
      store(2'b01, 32'h202, 32'h0000BEEF, 4'b0011, 32'h0000EFBE, 1'b1);
      @(negedge clk);
      chk("bh_count", {29'h0, count}, 32'h2);
      @(posedge clk); #1;
      ack(2);

      // Fill to capacity; fifth store held off.
      store(2'b10, 32'h400, 32'hA0A1A2A3, 4'b1111, 32'hA3A2A1A0, 1'b1);
      store(2'b10, 32'h404, 32'hB0B1B2B3, 4'b1111, 32'hB3B2B1B0, 1'b1);
      store(2'b10, 32'h408, 32'hC0C1C2C3, 4'b1111, 32'hC3C2C1C0, 1'b1);
      store(2'b10, 32'h40C, 32'hD0D1D2D3, 4'b1111, 32'hD3D2D1D0, 1'b1);
      @(negedge clk);
      chk("full_count", {29'h0, count}, 32'h4);
      chk("full_st_ready", {31'h0, st_ready}, 32'h0);
      @(posedge clk); #1;
      st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h410; st_data = 32'hEEEEEEEE;
      @(posedge clk); #1;
      st_valid = 1'b0;
      @(negedge clk);
      chk("full_holdoff_count", {29'h0, count}, 32'h4);
      @(posedge clk); #1;
      ack(4);
      @(negedge clk);
      chk("full_drained_empty", {31'h0, sb_empty}, 32'h1);
      chk("full_scoreboard_left", exp_q.size(), 32'h0);

      // Misaligned stores.
      @(posedge clk); #1;
      st_valid = 1'b1; st_size = 2'b01; st_addr = 32'h101; st_data = 32'h1234;
      @(negedge clk);
      chk("sh_misaligned_ades", {31'h0, st_ades}, 32'h1);
      @(posedge clk); #1;
      st_size = 2'b10; st_addr = 32'h102;
      @(negedge clk);
      chk("sw_misaligned_ades", {31'h0, st_ades}, 32'h1);
      chk("sh_misaligned_count", {29'h0, count}, 32'h0);
      @(posedge clk); #1;
      st_valid = 1'b0;
      @(negedge clk);
      chk("sw_misaligned_count", {29'h0, count}, 32'h0);

      // Load hazard against a pending byte store.
      @(posedge clk); #1;
      store(2'b00, 32'h106, 32'h0000005A, 4'b0010, 32'h00005A00, 1'b1);
      ld_check = 1'b1; ld_addr = 32'h104;
      @(negedge clk);
      chk("hazard_hit", {31'h0, ld_hazard}, 32'h1);
      @(posedge clk); #1;
      ld_addr = 32'h108;
      @(negedge clk);
      chk("hazard_miss", {31'h0, ld_hazard}, 32'h0);
      @(posedge clk); #1;
      ld_addr = 32'h104;
      ack(1);
      @(negedge clk);
      chk("hazard_after_ack", {31'h0, ld_hazard}, 32'h0);
      @(posedge clk); #1;
      ld_check = 1'b0;

      // Reset discards pending stores.
      store(2'b10, 32'h500, 32'h01010101, 4'b1111, 32'h01010101, 1'b1);
      store(2'b10, 32'h504, 32'h02020202, 4'b1111, 32'h02020202, 1'b1);
      store(2'b10, 32'h508, 32'h03030303, 4'b1111, 32'h03030303, 1'b1);
      @(negedge clk);
      chk("prerst_count", {29'h0, count}, 32'h3);
      @(posedge clk); #1;
      cpu_rst = 1'b1;
      @(posedge clk); #1;
      cpu_rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_count", {29'h0, count}, 32'h0);
      chk("midrst_dm_we", {28'h0, dm_we}, 32'h0);
      @(posedge clk); #1;
      dm_ack = 1'b1;
      @(negedge clk);
      chk("midrst_no_write", {28'h0, dm_we}, 32'h0);
      @(posedge clk); #1;
      dm_ack = 1'b0;

      // Same-word byte stores.
`ifdef STB_MERGE_EN
      store(2'b00, 32'h300, 32'h000000AA, 4'b1000, 32'hAA000000, 1'b0);
      store(2'b00, 32'h301, 32'h000000BB, 4'b1100, 32'hAABB0000, 1'b1);
      @(negedge clk);
      chk("merge_count", {29'h0, count}, 32'h1);
      chk("merge_we", {28'h0, dm_we}, 32'h0000000C);
      @(posedge clk); #1;
      ack(1);
`else
      store(2'b00, 32'h300, 32'h000000AA, 4'b1000, 32'hAA000000, 1'b1);
      store(2'b00, 32'h301, 32'h000000BB, 4'b0100, 32'h00BB0000, 1'b1);
      @(negedge clk);
      chk("nomerge_count", {29'h0, count}, 32'h2);
      @(posedge clk); #1;
      ack(2);
`endif
      @(negedge clk);
      chk("final_empty", {31'h0, sb_empty}, 32'h1);
      chk("final_scoreboard_left", exp_q.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
